// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue decoupling IFU from IDU; flush drops all queued entries.
// Optional FETCHQ_BYPASS_EN: zero-latency pass-through when the queue is empty.

`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

module ifu_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CPU_WIDTH = `CPU_WIDTH,
  parameter int unsigned INS_WIDTH = `INS_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  input  logic [CPU_WIDTH-1:0] i_pre_pc,
  input  logic [INS_WIDTH-1:0] i_pre_ins,
  input  logic                 i_flush,
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  output logic [CPU_WIDTH-1:0] o_post_pc,
  output logic [INS_WIDTH-1:0] o_post_ins
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     cnt;
  logic [CPU_WIDTH-1:0] pc_mem  [DEPTH];
  logic [INS_WIDTH-1:0] ins_mem [DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic byp_take;
  logic wr_en;
  logic rd_en;

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

  // Ready depends on occupancy only, so a full queue never pushes through a pop.
  assign o_pre_ready = !full;

`ifdef FETCHQ_BYPASS_EN
  assign o_post_valid = (!empty || i_pre_valid) && !i_flush;

  always_comb begin
    o_post_pc  = '0;
    o_post_ins = '0;
    if (!empty) begin
      o_post_pc  = pc_mem[rd_ptr];
      o_post_ins = ins_mem[rd_ptr];
    end else if (i_pre_valid) begin
      o_post_pc  = i_pre_pc;
      o_post_ins = i_pre_ins;
    end
  end

  // Entry handed straight to IDU: neither stored nor counted.
  assign byp_take = empty && i_pre_valid && i_post_ready && !i_flush;
`else
  assign o_post_valid = !empty && !i_flush;

  always_comb begin
    o_post_pc  = '0;
    o_post_ins = '0;
    if (!empty) begin
      o_post_pc  = pc_mem[rd_ptr];
      o_post_ins = ins_mem[rd_ptr];
    end
  end

  assign byp_take = 1'b0;
`endif

  assign push  = i_pre_valid && o_pre_ready;
  assign pop   = o_post_valid && i_post_ready;
  assign wr_en = push && !byp_take && !i_flush;
  assign rd_en = pop && !byp_take;

  // Payload storage is intentionally left unreset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr]  <= i_pre_pc;
      ins_mem[wr_ptr] <= i_pre_ins;
    end
  end

  // Pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
